// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared widths, reset PC, opcode constants and fetch FSM states.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   typedef enum logic [1:0] {
      IFU_IDLE = 2'd0,
      IFU_REQ  = 2'd1,
      IFU_DONE = 2'd2,
      IFU_ERR  = 2'd3
   } ifu_state_t;

endpackage

`default_nettype wire

// File: rtl/ifu_decode.sv
// ============================================================================
// Module   : ifu_decode
// Purpose  : Combinational slicing of an instruction word into decode fields.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ifu_decode
   import cpu_pkg::*;
(
   input  logic [31:0] ir,
   output logic [6:0]  opcode,
   output logic [2:0]  func3,
   output logic [6:0]  func7,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2
);

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign func3  = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign func7  = ir[31:25];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : PC/IR owner with req/ack instruction fetch and timeout error.
//            Optional macro IFU_MISALIGN_CHECK_EN rejects unaligned redirects.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int               XLEN         = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC     = cpu_pkg::RESET_PC,
   parameter int               IMEM_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst_,
   input  logic            fetch_en,
   input  logic            pc_inc,
   input  logic            pc_we,
   input  logic [XLEN-1:0] pc_wdata,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_ack,
   output logic [31:0]     ir,
   output logic [6:0]      opcode,
   output logic [2:0]      func3,
   output logic [6:0]      func7,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            fetch_done,
   output logic            busy,
   output logic            fetch_err,
   output logic            misalign
);

   // Last counter value at which an ack is still accepted.
   localparam logic [7:0] CNT_LAST = 8'(IMEM_TIMEOUT - 1);

   ifu_state_t      r_state;
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_ir;
   logic            r_req;
   logic            r_done;
   logic            r_err;
   logic            r_misalign;
   logic [7:0]      r_cnt;

   logic [XLEN-1:0] w_pc_plus4;

   assign w_pc_plus4 = r_pc + XLEN'(4);

`ifdef IFU_MISALIGN_CHECK_EN
   logic w_wdata_misaligned;
   assign w_wdata_misaligned = (pc_wdata[1:0] != 2'b00);
`else
   logic [XLEN-1:0] w_wdata_aligned;
   assign w_wdata_aligned = pc_wdata & ~XLEN'(3);
`endif

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state    <= IFU_IDLE;
         r_pc       <= RESET_PC;
         r_ir       <= 32'h0;
         r_req      <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_misalign <= 1'b0;
         r_cnt      <= 8'd0;
      end else begin
         r_done     <= 1'b0;
         r_misalign <= 1'b0;
         case (r_state)
            IFU_IDLE: begin
               // PC update and fetch launch share the edge, so REQ sees the new PC.
               if (pc_we) begin
`ifdef IFU_MISALIGN_CHECK_EN
                  if (w_wdata_misaligned) begin
                     r_misalign <= 1'b1;
                  end else begin
                     r_pc <= pc_wdata;
                  end
`else
                  r_pc <= w_wdata_aligned;
`endif
               end else if (pc_inc) begin
                  r_pc <= w_pc_plus4;
               end
               if (fetch_en) begin
                  r_state <= IFU_REQ;
                  r_req   <= 1'b1;
                  r_cnt   <= 8'd0;
               end
            end
            IFU_REQ: begin
               if (imem_ack) begin
                  r_ir    <= imem_rdata;
                  r_req   <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= IFU_DONE;
               end else if (r_cnt == CNT_LAST) begin
                  r_req   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= IFU_ERR;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            IFU_DONE: begin
               r_state <= IFU_IDLE;
            end
            IFU_ERR: begin
               r_state <= IFU_ERR;
            end
            default: begin
               r_state <= IFU_IDLE;
            end
         endcase
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign pc_plus4   = w_pc_plus4;
   assign ir         = r_ir;
   assign fetch_done = r_done;
   assign fetch_err  = r_err;
   assign misalign   = r_misalign;
   assign busy       = (r_state != IFU_IDLE);

   ifu_decode u_decode (
      .ir     (r_ir),
      .opcode (opcode),
      .func3  (func3),
      .func7  (func7),
      .rd     (rd),
      .rs1    (rs1),
      .rs2    (rs2)
   );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_;
   logic        fetch_en, pc_inc, pc_we;
   logic [31:0] pc_wdata;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] ir;
   logic [6:0]  opcode, func7;
   logic [2:0]  func3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] pc, pc_plus4;
   logic        fetch_done, busy, fetch_err, misalign;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .XLEN         (32),
      .RESET_PC     (32'h0000_0000),
      .IMEM_TIMEOUT (15)
   ) dut (
      .clk        (clk),
      .rst_       (rst_),
      .fetch_en   (fetch_en),
      .pc_inc     (pc_inc),
      .pc_we      (pc_we),
      .pc_wdata   (pc_wdata),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .ir         (ir),
      .opcode     (opcode),
      .func3      (func3),
      .func7      (func7),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .fetch_done (fetch_done),
      .busy       (busy),
      .fetch_err  (fetch_err),
      .misalign   (misalign)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance one rising edge and settle 1ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int req_cycles;

   initial begin
      rst_ = 1'b0; fetch_en = 1'b0; pc_inc = 1'b0; pc_we = 1'b0;
      pc_wdata = 32'h0; imem_rdata = 32'h0; imem_ack = 1'b0;
      tick(); tick();
      check("rst_req",   32'(imem_req),   32'h0);
      check("rst_pc",    pc,              32'h0);
      check("rst_ir",    ir,              32'h0);
      check("rst_done",  32'(fetch_done), 32'h0);
      check("rst_err",   32'(fetch_err),  32'h0);
      check("rst_busy",  32'(busy),       32'h0);
      check("rst_mis",   32'(misalign),   32'h0);
      rst_ = 1'b1;
      tick();

      // Fetch with ack ready on the first REQ cycle.
      fetch_en = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0030_0093;
      tick();
      fetch_en = 1'b0;
      check("f1_req",   32'(imem_req), 32'h1);
      check("f1_busy",  32'(busy),     32'h1);
      tick();
      imem_ack = 1'b0;
      check("f1_done",   32'(fetch_done), 32'h1);
      check("f1_ir",     ir,              32'h0030_0093);
      check("f1_opcode", 32'(opcode),     32'h13);
      check("f1_rd",     32'(rd),         32'h1);
      check("f1_rs1",    32'(rs1),        32'h0);
      check("f1_reqlow", 32'(imem_req),   32'h0);
      check("f1_pc",     pc,              32'h0);
      tick();
      check("f1_done_end", 32'(fetch_done), 32'h0);
      check("f1_idle",     32'(busy),       32'h0);

      // Redirect concurrent with fetch, ack delayed 5 cycles.
      pc_we = 1'b1; pc_wdata = 32'h40; fetch_en = 1'b1;
      tick();
      pc_we = 1'b0; fetch_en = 1'b0;
      req_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         if (imem_req) req_cycles++;
         check("f2_addr", imem_addr, 32'h40);
         if (i == 1) pc_inc = 1'b1;
         if (i == 2) pc_inc = 1'b0;
         if (i == 5) begin
            imem_ack = 1'b1; imem_rdata = 32'h40B5_0533;
         end
         tick();
      end
      imem_ack = 1'b0;
      check("f2_reqcyc", 32'(req_cycles), 32'd6);
      check("f2_reqlow", 32'(imem_req),   32'h0);
      check("f2_done",   32'(fetch_done), 32'h1);
      check("f2_ir",     ir,              32'h40B5_0533);
      check("f2_opcode", 32'(opcode),     32'h33);
      check("f2_func7",  32'(func7),      32'h20);
      check("f2_func3",  32'(func3),      32'h0);
      check("f2_rd",     32'(rd),         32'd10);
      check("f2_rs1",    32'(rs1),        32'd10);
      check("f2_rs2",    32'(rs2),        32'd11);
      check("f2_pc_busy_ignored", pc,     32'h40);
      tick();
      check("f2_done_end", 32'(fetch_done), 32'h0);

      // PC write has priority over increment; increment; wrap.
      pc_we = 1'b1; pc_inc = 1'b1; pc_wdata = 32'h100;
      tick();
      pc_we = 1'b0;
      check("pc_we_pri", pc, 32'h100);
      tick();
      pc_inc = 1'b0;
      check("pc_inc",    pc,       32'h104);
      check("pc_plus4",  pc_plus4, 32'h108);
      pc_we = 1'b1; pc_wdata = 32'hFFFF_FFFC;
      tick();
      pc_we = 1'b0;
      check("pc_top",       pc,       32'hFFFF_FFFC);
      check("pc_top_plus4", pc_plus4, 32'h0);
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      check("pc_wrap",       pc,       32'h0);
      check("pc_wrap_plus4", pc_plus4, 32'h4);

      // Unaligned redirect: either rejected (pc stays 0x100) or aligned to 0x100.
      pc_we = 1'b1; pc_wdata = 32'h100;
      tick();
      pc_wdata = 32'h102;
      tick();
      pc_we = 1'b0;
      check("mis_pc", pc, 32'h100);
`ifdef IFU_MISALIGN_CHECK_EN
      check("mis_pulse", 32'(misalign), 32'h1);
`else
      check("mis_pulse", 32'(misalign), 32'h0);
`endif
      tick();
      check("mis_end", 32'(misalign), 32'h0);

      // Timeout: no ack, 15 request cycles then ERR.
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      req_cycles = 0;
      for (int g = 0; g < 40 && imem_req; g++) begin
         req_cycles++;
         tick();
      end
      check("to_reqcyc", 32'(req_cycles), 32'd15);
      check("to_err",    32'(fetch_err),  32'h1);
      check("to_req",    32'(imem_req),   32'h0);
      check("to_busy",   32'(busy),       32'h1);
      fetch_en = 1'b1; imem_ack = 1'b1; pc_inc = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick(); tick(); tick();
      fetch_en = 1'b0; imem_ack = 1'b0; pc_inc = 1'b0;
      check("err_req",  32'(imem_req),   32'h0);
      check("err_pc",   pc,              32'h100);
      check("err_ir",   ir,              32'h40B5_0533);
      check("err_done", 32'(fetch_done), 32'h0);
      check("err_sticky", 32'(fetch_err), 32'h1);

      // Reset clears ERR; then async reset mid-fetch.
      rst_ = 1'b0;
      #2;
      check("rst2_err", 32'(fetch_err), 32'h0);
      tick();
      rst_ = 1'b1;
      tick();
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      check("ar_req_on", 32'(imem_req), 32'h1);
      #2;
      rst_ = 1'b0;
      #1;
      check("ar_req_async", 32'(imem_req), 32'h0);
      tick();
      rst_ = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      imem_ack = 1'b0;
      check("ar_busy", 32'(busy),       32'h0);
      check("ar_req",  32'(imem_req),   32'h0);
      check("ar_ir",   ir,              32'h0);
      check("ar_pc",   pc,              32'h0);
      check("ar_done", 32'(fetch_done), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream feeder of the multi-cycle control state machine. Owns the program counter and instruction register and runs a request/acknowledge fetch from instruction memory. Slices the latched instruction into the opcode/func3/func7/register fields the controller decodes. Advances or redirects the PC on command from the controller's write-back and jump states.

## Interface
Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, PC value after reset
- IMEM_TIMEOUT, 15, max cycles to wait for imem_ack before error (1..255)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_  in  1  reset, asynchronous, active-low
- fetch_en  in  1  start fetch at current PC (sampled in IDLE only)
- pc_inc  in  1  PC <= PC+4 (IDLE only)
- pc_we  in  1  PC <= pc_wdata (IDLE only; priority over pc_inc)
- pc_wdata  in  XLEN  redirect target
- imem_req  out  1  memory request, registered
- imem_addr  out  XLEN  fetch address, equals pc
- imem_rdata  in  32  instruction word, valid with imem_ack
- imem_ack  in  1  memory response strobe
- ir  out  32  instruction register
- opcode  out  7  ir[6:0]
- func3  out  3  ir[14:12]
- func7  out  7  ir[31:25]
- rd, rs1, rs2  out  5 each  ir[11:7], ir[19:15], ir[24:20]
- pc  out  XLEN  current PC
- pc_plus4  out  XLEN  pc+4, wraps modulo 2^XLEN
- fetch_done  out  1  one-cycle pulse, ir freshly valid
- busy  out  1  state != IDLE
- fetch_err  out  1  sticky timeout flag
- misalign  out  1  one-cycle pulse, rejected redirect (see Configuration)

## Operation
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE: fetch_en=1 -> REQ, imem_req<=1, timeout counter <=0. Else apply pc_we or pc_inc. fetch_en and pc_we/pc_inc in the same cycle: PC update applies and the fetch uses the updated PC.
- REQ: imem_req held 1, imem_addr stable. imem_ack=1 -> ir<=imem_rdata, imem_req<=0, -> DONE. Else counter++. Counter reaching IMEM_TIMEOUT without ack -> ERR, imem_req<=0, fetch_err<=1.
- DONE: fetch_done=1 for this single cycle -> IDLE.
- ERR: terminal; only rst_ exits. fetch_en, pc_we, pc_inc are ignored.
- pc_we/pc_inc/fetch_en while busy are ignored, not queued.
- imem_ack outside REQ is ignored.
- Field outputs are combinational from ir. ir changes only on an accepted ack.
- Reset values: pc=RESET_PC, ir=0 (opcode 0, matches no instruction class), imem_req=0, fetch_done=0, fetch_err=0, misalign=0, state IDLE, counter 0.
- rst_ asserted mid-fetch aborts immediately: imem_req drops asynchronously. A late ack after release is ignored because the FSM is in IDLE.

## Timing
- fetch_en at edge N -> imem_req=1 from N+1.
- Ack sampled at edge N+k (k>=1) -> ir valid and fetch_done=1 during cycle N+k+1 -> IDLE at N+k+2.
- Minimum fetch latency, fetch_en to fetch_done: 2 cycles.
- Ack sampled at the edge where counter == IMEM_TIMEOUT-1 is accepted. Counter == IMEM_TIMEOUT -> ERR. The ack window is exactly IMEM_TIMEOUT cycles of imem_req high.
- PC updates are visible on pc/imem_addr the cycle after the command edge.

## Configuration
- IFU_MISALIGN_CHECK_EN defined: a pc_we with pc_wdata[1:0] != 0 is suppressed (PC unchanged) and misalign pulses for one cycle. The pulse also occurs for a concurrent fetch_en, which then fetches from the old PC.
- Not defined: PC <= {pc_wdata[XLEN-1:2], 2'b00}. misalign is tied to 0.

## Structure
- Shared package cpu_pkg: XLEN, RESET_PC, opcode constants (OP_R, OP_IMM, OP_LUI, OP_STORE, OP_BRANCH, OP_JAL), and the fetch FSM state enum ifu_state_t.
- One sub-module, ifu_decode: purely combinational field slicing of ir into opcode/func3/func7/rd/rs1/rs2. It is reused by the controller bench.

## Test plan
- Reset, then fetch_en with ack on the first REQ cycle and rdata=32'h0030_0093 -> fetch_done 2 cycles after fetch_en; opcode=7'h13, rd=1, ir as given; pc unchanged at 0.
- Ack delayed 5 cycles -> imem_req high for exactly 6 cycles; imem_addr constant throughout; fetch_done exactly 1 cycle.
- No ack with IMEM_TIMEOUT=15 -> ERR after 15 req cycles; fetch_err=1, imem_req=0; a later fetch_en, ack, or pc_inc has no effect until rst_.
- pc_we=1 and pc_inc=1 together with pc_wdata=32'h100 -> pc=32'h100. Then pc_inc -> 32'h104. At pc=32'hFFFF_FFFC, pc_inc -> pc=0 and pc_plus4=4.
- pc_wdata=32'h102: with IFU_MISALIGN_CHECK_EN, pc is unchanged and misalign pulses once. Without it, pc=32'h100 and misalign stays 0.
- rst_ low during REQ -> imem_req=0 without waiting for clk; after release, an ack is ignored, pc=RESET_PC and ir=0.
